// File: rtl/time_verifier_param_if.sv
// ---------------------------------------------------------------------------
// time_verifier_param_if
//   Bundle of the control, configuration and status signals of the
//   operation-latency verifier.
//
//   master modport (stimulus side):
//     CStart, CEnd, ErrorRst          -> start / end / error-clear requests
//     LatMin, LatMax [CNT_W]          -> legal latency window in cycles
//     Error, ErrCode[3], Busy, Done,  <- verifier status
//     CycleCount[CNT_W], ErrCount[ERR_CNT_W]
//   slave modport: the verifier itself, directions mirrored.
// ---------------------------------------------------------------------------
interface time_verifier_param_if #(
  parameter int CNT_W     = 8,
  parameter int ERR_CNT_W = 8
);
  logic                 CStart;
  logic                 CEnd;
  logic                 ErrorRst;
  logic [CNT_W-1:0]     LatMin;
  logic [CNT_W-1:0]     LatMax;
  logic                 Error;
  logic [2:0]           ErrCode;
  logic                 Busy;
  logic                 Done;
  logic [CNT_W-1:0]     CycleCount;
  logic [ERR_CNT_W-1:0] ErrCount;

  modport master (
    output CStart, CEnd, ErrorRst, LatMin, LatMax,
    input  Error, ErrCode, Busy, Done, CycleCount, ErrCount
  );

  modport slave (
    input  CStart, CEnd, ErrorRst, LatMin, LatMax,
    output Error, ErrCode, Busy, Done, CycleCount, ErrCount
  );
endinterface

// File: rtl/time_verifier_param.sv
// ---------------------------------------------------------------------------
// time_verifier_param
//   Checks that every operation bracketed by CStart ... CEnd completes within
//   a latency window [LatMin, LatMax] sampled at the start, and flags
//   protocol violations with a sticky error and cause code.
//
//   Ports:
//     Clk  - single rising-edge clock
//     Rst  - synchronous active-high reset, overrides everything
//     bus  - time_verifier_param_if.slave (requests, bounds, status)
//
//   Status outputs are decoded from the state register or driven straight
//   from registers, so none of them depends combinationally on an input.
// ---------------------------------------------------------------------------
module time_verifier_param #(
  parameter int CNT_W     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  time_verifier_param_if.slave  bus
);

  typedef enum logic [1:0] {
    S_Wait,
    S_Count,
    S_Done,
    S_Error
  } state_t;

  typedef enum logic [2:0] {
    E_NONE       = 3'd0,
    E_EARLY      = 3'd1,
    E_LATE       = 3'd2,
    E_OVERLAP    = 3'd3,
    E_DOUBLE_END = 3'd4,
    E_CFG        = 3'd5,
    E_ORPHAN_END = 3'd6
  } err_code_t;

  state_t                state;
  state_t                state_next;
  err_code_t             err_code;
  err_code_t             err_cause;   // cause recorded when entering S_Error
  logic [CNT_W-1:0]      cycle_count;
  logic [CNT_W-1:0]      lat_min;
  logic [CNT_W-1:0]      lat_max;
  logic [ERR_CNT_W-1:0]  err_count;
  logic                  cfg_ok;
  logic                  start_run;   // load bounds and restart the count
  logic                  count_inc;

  // A start is legal only with a non-empty window that excludes zero.
  assign cfg_ok = (bus.LatMin != '0) && (bus.LatMin <= bus.LatMax);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: registers are written with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_Wait;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, otherwise paths
  // that skip an assignment would infer latches.
  always_comb begin
    state_next = state;
    err_cause  = E_NONE;
    start_run  = 1'b0;
    count_inc  = 1'b0;

    unique case (state)
      S_Wait: begin
        // CStart wins over a simultaneous CEnd.
        if (bus.CStart) begin
          if (cfg_ok) begin
            state_next = S_Count;
            start_run  = 1'b1;
          end else begin
            state_next = S_Error;
            err_cause  = E_CFG;
          end
        end else if (bus.CEnd) begin
          state_next = S_Error;
          err_cause  = E_ORPHAN_END;
        end
      end

      S_Count: begin
        if (bus.CStart) begin
          state_next = S_Error;
          err_cause  = E_OVERLAP;
        end else if (bus.CEnd) begin
          if (cycle_count < lat_min) begin
            state_next = S_Error;
            err_cause  = E_EARLY;
          end else begin
            state_next = S_Done;
          end
        end else if (cycle_count == lat_max) begin
          // The window is exhausted; the count never passes lat_max, which
          // is what keeps it from wrapping.
          state_next = S_Error;
          err_cause  = E_LATE;
        end else begin
          count_inc = 1'b1;
        end
      end

      S_Done: begin
        if (bus.CEnd) begin
          state_next = S_Error;
          err_cause  = E_DOUBLE_END;
        end else if (bus.CStart) begin
          if (cfg_ok) begin
            state_next = S_Count;
            start_run  = 1'b1;
          end else begin
            state_next = S_Error;
            err_cause  = E_CFG;
          end
        end else begin
          state_next = S_Wait;
        end
      end

      S_Error: begin
        if (bus.ErrorRst) begin
          state_next = S_Wait;
        end
      end

      default: state_next = S_Wait;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers: bounds, cycle count, error code, error counter
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      lat_min     <= '0;
      lat_max     <= '0;
      cycle_count <= '0;
      err_code    <= E_NONE;
      err_count   <= '0;
    end else begin
      if (start_run) begin
        lat_min     <= bus.LatMin;
        lat_max     <= bus.LatMax;
        cycle_count <= CNT_W'(1);
      end else if (count_inc) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end

      if ((state_next == S_Error) && (state != S_Error)) begin
        err_code <= err_cause;
        if (err_count != {ERR_CNT_W{1'b1}}) begin
          err_count <= err_count + ERR_CNT_W'(1);
        end
      end else if ((state == S_Error) && (state_next == S_Wait)) begin
        err_code <= E_NONE;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output decode (registered state only)
  // -------------------------------------------------------------------------
  always_comb begin
    bus.Busy       = (state == S_Count);
    bus.Done       = (state == S_Done);
    bus.Error      = (state == S_Error);
    bus.ErrCode    = err_code;
    bus.CycleCount = cycle_count;
    bus.ErrCount   = err_count;
  end

endmodule
